// File: rtl/rca_pkg.sv
// Shared constants and types for the registered ripple-carry adder.
package rca_pkg;

   localparam int RCA_DEF_WIDTH = 4;

   function automatic int rca_res_w(input int w);
      return w + 1;
   endfunction

   typedef logic [RCA_DEF_WIDTH:0] rca_res_t;

endpackage

// File: rtl/rca_full_adder.sv
// Single full-adder cell, written as explicit gates so the chain keeps its structure.
module rca_full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic p;

   assign p  = a ^ b;
   assign s  = p ^ ci;
   assign co = (a & b) | (ci & p);

endmodule

// File: rtl/rca_4b.sv
// Registered ripple-carry adder: {co, sum} = in0 + in1 + in2, one cycle latency.
// Optional status outputs (out_zero, out_ovf) are enabled by defining RCA_4B_STATUS_EN.
module rca_4b
   import rca_pkg::*;
#(
   parameter int WIDTH = RCA_DEF_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     in0,
   input  logic [WIDTH-1:0]     in1,
   input  logic                 in2,
   output logic [WIDTH:0]       out0,
   output logic                 out_valid
`ifdef RCA_4B_STATUS_EN
   ,
   output logic                 out_zero,
   output logic                 out_ovf
`endif
);

   localparam int RES_W = rca_res_w(WIDTH);

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;
   logic [RES_W-1:0] res_d, res_q;
   logic             vld_q;

   assign c[0] = in2;

   for (genvar g = 0; g < WIDTH; g++) begin : g_fa
      rca_full_adder u_fa (
         .a  (in0[g]),
         .b  (in1[g]),
         .ci (c[g]),
         .s  (s[g]),
         .co (c[g+1])
      );
   end

   assign res_d = {c[WIDTH], s};

   // out0 holds across idle cycles; only the valid flag drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
         vld_q <= 1'b0;
      end else begin
         vld_q <= in_valid;
         if (in_valid) res_q <= res_d;
      end
   end

   assign out0      = res_q;
   assign out_valid = vld_q;

`ifdef RCA_4B_STATUS_EN
   logic zero_d, zero_q;
   logic ovf_d, ovf_q;

   // Signed overflow: carry into the MSB differs from carry out of it.
   assign zero_d = (res_d == '0);
   assign ovf_d  = c[WIDTH] ^ c[WIDTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (in_valid) begin
         zero_q <= zero_d;
         ovf_q  <= ovf_d;
      end
   end

   assign out_zero = zero_q;
   assign out_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_rca_4b.sv
// Scoreboard bench for rca_4b: driver pushes expected results, monitor pops on out_valid.
module tb_rca_4b;

   typedef struct {
      logic [4:0] sum;
      logic       zero;
      logic       ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] in0, in1;
   logic       in2;
   logic [4:0] out0;
   logic       out_valid;
`ifdef RCA_4B_STATUS_EN
   logic       out_zero, out_ovf;
`endif

   exp_t       sb[$];
   logic [4:0] hold_val;
   int         npass = 0;
   int         ntot  = 0;

   rca_4b #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in0       (in0),
      .in1       (in1),
      .in2       (in2),
      .out0      (out0),
      .out_valid (out_valid)
`ifdef RCA_4B_STATUS_EN
      ,
      .out_zero  (out_zero),
      .out_ovf   (out_ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci,
                        input logic v, input logic [4:0] esum, input logic ez,
                        input logic eovf);
      exp_t e;
      @(negedge clk);
      in0 = a; in1 = b; in2 = ci; in_valid = v;
      if (v) begin
         e.sum = esum; e.zero = ez; e.ovf = eovf;
         sb.push_back(e);
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n === 1'b1) begin
         if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("sum", {27'd0, out0}, {27'd0, e.sum});
`ifdef RCA_4B_STATUS_EN
               chk("zero", {31'd0, out_zero}, {31'd0, e.zero});
               chk("ovf",  {31'd0, out_ovf},  {31'd0, e.ovf});
`endif
               hold_val = e.sum;
            end
         end else begin
            if (sb.size() != 0) begin
               chk("missing_valid", {31'd0, out_valid}, 1);
               void'(sb.pop_front());
            end
            chk("hold", {27'd0, out0}, {27'd0, hold_val});
         end
      end
   end

   initial begin
      int s_signed;
      logic [4:0] es;
      rst_n = 1'b0; in_valid = 1'b0; in0 = '0; in1 = '0; in2 = 1'b0;
      hold_val = '0;
      repeat (2) @(negedge clk);
      chk("por_out0",  {27'd0, out0}, 0);
      chk("por_valid", {31'd0, out_valid}, 0);
      rst_n = 1'b1;

      // Directed vectors: a, b, cin, valid, sum, zero, ovf
      drive(4'd0,  4'd0,  1'b0, 1'b1, 5'd0,  1'b1, 1'b0);
      drive(4'd15, 4'd15, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0);
      drive(4'd15, 4'd0,  1'b1, 1'b1, 5'd16, 1'b0, 1'b0);
      drive(4'd4,  4'd5,  1'b0, 1'b1, 5'd9,  1'b0, 1'b1);
      drive(4'd7,  4'd7,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0);
      drive(4'd7,  4'd7,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0);
      drive(4'd7,  4'd1,  1'b0, 1'b1, 5'd8,  1'b0, 1'b1);
      drive(4'd8,  4'd8,  1'b0, 1'b1, 5'd16, 1'b0, 1'b1);
      drive(4'd15, 4'd15, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0);
      drive(4'd0,  4'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0);

      // Asynchronous reset between edges with out0 holding 31.
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out0",  {27'd0, out0}, 0);
      chk("async_rst_valid", {31'd0, out_valid}, 0);
      sb.delete();
      hold_val = '0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'd0, 4'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

      // Back-to-back sweep of every operand combination.
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++) begin
               es = 5'(a + b + c);
               s_signed = int'($signed(4'(a))) + int'($signed(4'(b))) + c;
               drive(4'(a), 4'(b), 1'(c), 1'b1, es, (es == 0),
                     (s_signed > 7) || (s_signed < -8));
            end
      drive(4'd3, 4'd3, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

      for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
